uart_tx_frame: RTL
==================

# uart_tx_frame

Serial UART transmitter that consumes the 32-bit configuration word produced by the UART configuration register stage, together with a byte stream on a valid/ready handshake. It emits standard asynchronous frames on a single output line: a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. The configuration is sampled once per frame, so a configuration update never corrupts a frame already in flight.

## Interface

- CONFIG_WIDTH, 32, width of the configuration word; must be ≥ 19.
- clock  in  1  single system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- conf  in  CONFIG_WIDTH  configuration word from the configuration stage:
  - [15:0] cycles per bit, N.
  - [16] parity enable.
  - [17] parity odd (0 = even).
  - [18] two stop bits.
  - Remaining bits are ignored.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block accepts a byte this cycle.
- tx  out  1  serial line; idle high.
- busy  out  1  a frame is in progress.

## Operation

- **Reset values:** tx=1, tx_ready=1, busy=0, state IDLE, all counters 0.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - tx=1, tx_ready=1, busy=0.
  - On tx_valid & tx_ready, on that edge:
    - latch tx_data into the shift register;
    - latch conf[18:0] into a frame-config register;
    - compute parity = ^tx_data XOR odd;
    - go to START.
- **Per-bit duration:** bit time Nf = latched N, with N=0 treated as 1. The bit-cycle counter counts 0..Nf-1. The state/bit advances when the counter reaches Nf-1, and the counter then returns to 0.
- **START:** tx=0 for Nf cycles, then DATA with bit index 0.
- **DATA:**
  - tx = shift[0] for Nf cycles per bit.
  - Shift right after each bit and increment the index.
  - After bit 7, go to PARITY if the latched parity-enable is 1, else STOP.
- **PARITY:** tx = computed parity for Nf cycles, then STOP.
- **STOP:**
  - tx=1 for Nf cycles (1 stop bit) or 2·Nf cycles (2 stop bits).
  - Then go to IDLE.
- **Outside IDLE:** tx_ready=0 and busy=1 in every state other than IDLE. tx_valid is ignored there; the byte is held by the upstream producer.
- **Config changes:** changes on conf during a frame have no effect until the next acceptance.
- **Counter width:** the bit counter is 16 bits. N=0xFFFF is a legal maximum, and the counter must not wrap before Nf-1.
- **Registered outputs:** tx, tx_ready and busy are all registered. There is no combinational path from any input to any output.

## Timing

- **Acceptance:** the handshake completes at the edge where tx_valid=tx_ready=1 (edge T).
  - From edge T, tx=0, tx_ready=0 and busy=1.
  - The start bit occupies exactly Nf cycles after T.
- **Frame length:** Nf·(10 + P + S) cycles from edge T to the return of tx_ready=1, where P = parity enable and S = two-stop flag. With N=0x62 (98), 8N1 takes 980 cycles.
- **Back-to-back frames:**
  - tx_ready rises on the edge that ends the last stop bit.
  - If tx_valid is held high, the next byte is accepted on the following edge. This gives exactly 1 idle-high cycle between frames.
  - Throughput: one byte per Nf·(10+P+S)+1 cycles.
- **Reset mid-frame:**
  - Asynchronous reset forces tx=1, tx_ready=1 and busy=0 immediately, with no partial bits after release.
  - The first acceptance can occur on the first rising edge after reset deasserts.
- **N=1:** each bit lasts 1 cycle, so 8N1 completes in 10 cycles.

## Test plan

- **8N1, basic byte:** reset; N=98, parity off, 1 stop; send 0x55 → tx is
  - low for 98 cycles;
  - then 1,0,1,0,1,0,1,0 at 98 cycles each;
  - then high for 98 cycles;
  - tx_ready returns 980 cycles after acceptance.
- **Even and odd parity:** N=4, parity on, even; send 0x07 → parity bit 1, frame 44 cycles. Repeat with odd → parity bit 0.
- **Two stop bits and back-to-back:** N=2, two stop bits, tx_valid held high with 0xA5 then 0x3C → frames of 22 cycles each, with exactly 1 idle cycle between them; both bytes are reproduced LSB first.
- **Config change mid-frame:** start 0xFF with N=10. At cycle 30, change conf to N=3 with parity on → the current frame stays at 100 cycles with no parity; the next frame uses N=3 with parity (33 cycles).
- **Reset mid-frame:** assert reset 150 cycles into an N=98 frame → tx=1, busy=0 and tx_ready=1 asynchronously. After release, 0x00 sends correctly.
- **Degenerate divisor:** N=0 and N=1, send 0x81 → both produce a 10-cycle frame reading 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake plus configuration word and serial line of the UART transmitter.
// The master is the byte producer; the slave is the transmitter.
interface uart_tx_frame_if #(
  parameter int CONFIG_WIDTH = 32
);
  logic [CONFIG_WIDTH-1:0] conf;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    tx;
  logic                    busy;

  modport master (
    output conf, tx_data, tx_valid,
    input  tx_ready, tx, busy
  );

  modport slave (
    input  conf, tx_data, tx_valid,
    output tx_ready, tx, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Configuration is captured with each accepted byte, so in-flight frames are never altered.
module uart_tx_frame (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_tx_frame_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [18:0] cfg_q, cfg_d;
  logic        par_q, par_d;
  logic        stop2_q, stop2_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [15:0] last_cnt;
  logic        bit_end;
  logic        unused_conf;

  // A divisor of 0 behaves as 1, so the last count is 0 in both cases.
  assign last_cnt    = (cfg_q[15:0] == 16'd0) ? 16'd0 : cfg_q[15:0] - 16'd1;
  assign bit_end     = (cnt_q == last_cnt);
  assign unused_conf = ^bus.conf;

  always_comb begin
    state_d = state_q;
    cnt_d   = (bit_end) ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    stop2_d = stop2_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (bus.tx_valid && ready_q) begin
          shift_d = bus.tx_data;
          cfg_d   = bus.conf[18:0];
          par_d   = (^bus.tx_data) ^ bus.conf[17];
          idx_d   = 3'd0;
          stop2_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = cfg_q[16] ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cfg_q[18] && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line changes on the same edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      cfg_q   <= 19'd0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
endmodule
